// File: rtl/ac97_sdi_receiver.sv
// AC97 SDI receiver: deserializes codec frames aligned to AC97Sync and
// commits the tag, status and PCM capture slots with one-cycle valid pulses.
module ac97_sdi_receiver (
  input  logic        AC97BitClock,
  input  logic        Reset,
  input  logic        AC97SDI,
  input  logic        AC97Sync,
  output logic [15:0] tag,
  output logic        codec_ready,
  output logic [6:0]  status_addr,
  output logic [15:0] status_data,
  output logic [19:0] pcm_left,
  output logic [19:0] pcm_right,
  output logic        frame_valid,
  output logic        status_valid,
  output logic        pcm_valid,
  output logic        locked,
  output logic        frame_err
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic        sync_q;
  logic        rise, active, commit, err;
  logic [7:0]  nxt;

  logic [19:0] sh_q, sh_d;
  logic [15:0] tag_h_q, tag_h_d;
  logic [6:0]  s1_h_q, s1_h_d;
  logic [15:0] s2_h_q, s2_h_d;
  logic [19:0] s3_h_q, s3_h_d;
  logic [19:0] s4_h_q, s4_h_d;

  logic [15:0] tag_q, tag_d;
  logic [6:0]  sa_q, sa_d;
  logic [15:0] sd_q, sd_d;
  logic [19:0] pl_q, pl_d;
  logic [19:0] pr_q, pr_d;
  logic        fv_q, fv_d;
  logic        sv_q, sv_d;
  logic        pv_q, pv_d;
  logic        fe_q, fe_d;

  always_ff @(posedge AC97BitClock or posedge Reset) begin
    if (Reset) begin
      state_q   <= HUNT;
      bit_cnt_q <= 8'd0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sync_q    <= AC97Sync;
    end
  end

  // bit_cnt_d is the index of the bit sampled on this edge when active
  always_comb begin
    rise      = AC97Sync & ~sync_q;
    nxt       = bit_cnt_q + 8'd1;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    active    = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      HUNT: begin
        bit_cnt_d = 8'd0;
        if (rise) begin
          state_d = LOCK;
          active  = 1'b1;
        end
      end
      LOCK: begin
        if (rise) begin
          bit_cnt_d = 8'd0;
          active    = 1'b1;
          commit    = (nxt == 8'd0);
          err       = (nxt != 8'd0);
        end else if (nxt == 8'd0) begin
          state_d   = HUNT;
          bit_cnt_d = 8'd0;
          err       = 1'b1;
        end else begin
          bit_cnt_d = nxt;
          active    = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    sh_d    = {sh_q[18:0], AC97SDI};
    tag_h_d = tag_h_q;
    s1_h_d  = s1_h_q;
    s2_h_d  = s2_h_q;
    s3_h_d  = s3_h_q;
    s4_h_d  = s4_h_q;
    if (active) begin
      unique case (bit_cnt_d)
        8'd15:   tag_h_d = sh_d[15:0];
        8'd35:   s1_h_d  = sh_d[18:12];
        8'd55:   s2_h_d  = sh_d[19:4];
        8'd75:   s3_h_d  = sh_d;
        8'd95:   s4_h_d  = sh_d;
        default: ;
      endcase
    end
  end

  always_comb begin
    tag_d = tag_q;
    sa_d  = sa_q;
    sd_d  = sd_q;
    pl_d  = pl_q;
    pr_d  = pr_q;
    fv_d  = 1'b0;
    sv_d  = 1'b0;
    pv_d  = 1'b0;
    fe_d  = err;
    if (commit) begin
      tag_d = tag_h_q;
      fv_d  = 1'b1;
      if (tag_h_q[14] && tag_h_q[13]) begin
        sa_d = s1_h_q;
        sd_d = s2_h_q;
        sv_d = 1'b1;
      end
      if (tag_h_q[12]) pl_d = s3_h_q;
      if (tag_h_q[11]) pr_d = s4_h_q;
      pv_d = tag_h_q[12] | tag_h_q[11];
    end
  end

  always_ff @(posedge AC97BitClock or posedge Reset) begin
    if (Reset) begin
      sh_q    <= '0;
      tag_h_q <= '0;
      s1_h_q  <= '0;
      s2_h_q  <= '0;
      s3_h_q  <= '0;
      s4_h_q  <= '0;
      tag_q   <= '0;
      sa_q    <= '0;
      sd_q    <= '0;
      pl_q    <= '0;
      pr_q    <= '0;
      fv_q    <= 1'b0;
      sv_q    <= 1'b0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      tag_h_q <= tag_h_d;
      s1_h_q  <= s1_h_d;
      s2_h_q  <= s2_h_d;
      s3_h_q  <= s3_h_d;
      s4_h_q  <= s4_h_d;
      tag_q   <= tag_d;
      sa_q    <= sa_d;
      sd_q    <= sd_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      fv_q    <= fv_d;
      sv_q    <= sv_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
    end
  end

  assign tag          = tag_q;
  assign codec_ready  = tag_q[15];
  assign status_addr  = sa_q;
  assign status_data  = sd_q;
  assign pcm_left     = pl_q;
  assign pcm_right    = pr_q;
  assign frame_valid  = fv_q;
  assign status_valid = sv_q;
  assign pcm_valid    = pv_q;
  assign frame_err    = fe_q;
  assign locked       = (state_q == LOCK);

endmodule

// File: tb/tb_ac97_sdi_receiver.sv
// Scoreboard bench for ac97_sdi_receiver: frames are driven serially,
// expected commits/errors are queued and checked by an independent monitor.
module tb_ac97_sdi_receiver;

  typedef struct {
    logic [15:0] tag;
    logic [6:0]  sa;
    logic [15:0] sd;
    logic [19:0] pl;
    logic [19:0] pr;
    logic        sv;
    logic        pv;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset, sdi, sync;
  logic [15:0] tag;
  logic        codec_ready;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic [19:0] pcm_left, pcm_right;
  logic        frame_valid, status_valid, pcm_valid, locked, frame_err;

  ac97_sdi_receiver dut (
    .AC97BitClock(clk),
    .Reset(Reset),
    .AC97SDI(sdi),
    .AC97Sync(sync),
    .tag(tag),
    .codec_ready(codec_ready),
    .status_addr(status_addr),
    .status_data(status_data),
    .pcm_left(pcm_left),
    .pcm_right(pcm_right),
    .frame_valid(frame_valid),
    .status_valid(status_valid),
    .pcm_valid(pcm_valid),
    .locked(locked),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  exp_t cq[$];
  int   eq[$];
  exp_t mon_e;
  int   mon_c;

  logic [15:0] m_tag;
  logic [6:0]  m_sa;
  logic [15:0] m_sd;
  logic [19:0] m_pl, m_pr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got frame_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = cq.pop_front();
        chk("commit_cycle", cyc, mon_e.cyc);
        chk("tag", tag, mon_e.tag);
        chk("codec_ready", codec_ready, mon_e.tag[15]);
        chk("status_addr", status_addr, mon_e.sa);
        chk("status_data", status_data, mon_e.sd);
        chk("pcm_left", pcm_left, mon_e.pl);
        chk("pcm_right", pcm_right, mon_e.pr);
        chk("status_valid", status_valid, mon_e.sv);
        chk("pcm_valid", pcm_valid, mon_e.pv);
      end
    end else if (status_valid === 1'b1 || pcm_valid === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL stray_valid: got sv=%0b pv=%0b, expected 0 (cycle %0d)",
               status_valid, pcm_valid, cyc);
    end
    if (frame_err === 1'b1) begin
      if (eq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_err: got frame_err=1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_c = eq.pop_front();
        chk("err_cycle", cyc, mon_c);
      end
    end
  end

  task automatic send_frame(input logic [15:0] t, input logic [19:0] s1,
                            input logic [19:0] s2, input logic [19:0] s3,
                            input logic [19:0] s4, input bit sy,
                            input int nbits, input bit commits,
                            input bit err0);
    logic [255:0] f;
    exp_t e;
    int start;
    f = '0;
    f[255 -: 16] = t;
    f[239 -: 20] = s1;
    f[219 -: 20] = s2;
    f[199 -: 20] = s3;
    f[179 -: 20] = s4;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sdi  = f[255 - i];
      sync = sy && (i < 16);
      if (i == 0) begin
        start = cyc + 1;
        if (err0) eq.push_back(start);
        if (commits) begin
          m_tag = t;
          if (t[14] && t[13]) begin
            m_sa = s1[18:12];
            m_sd = s2[19:4];
          end
          if (t[12]) m_pl = s3;
          if (t[11]) m_pr = s4;
          e.tag = m_tag;
          e.sa  = m_sa;
          e.sd  = m_sd;
          e.pl  = m_pl;
          e.pr  = m_pr;
          e.sv  = t[14] & t[13];
          e.pv  = t[12] | t[11];
          e.cyc = start + 256;
          cq.push_back(e);
        end
      end
    end
  endtask

  task automatic clear_model();
    m_tag = '0;
    m_sa  = '0;
    m_sd  = '0;
    m_pl  = '0;
    m_pr  = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_tag"}, tag, 0);
    chk({p, "_codec_ready"}, codec_ready, 0);
    chk({p, "_status_addr"}, status_addr, 0);
    chk({p, "_status_data"}, status_data, 0);
    chk({p, "_pcm_left"}, pcm_left, 0);
    chk({p, "_pcm_right"}, pcm_right, 0);
    chk({p, "_frame_valid"}, frame_valid, 0);
    chk({p, "_status_valid"}, status_valid, 0);
    chk({p, "_pcm_valid"}, pcm_valid, 0);
    chk({p, "_locked"}, locked, 0);
    chk({p, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    clear_model();
    Reset = 1'b1;
    sdi   = 1'b0;
    sync  = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("hunt_locked", locked, 0);

    // steady frames, then tag gating
    send_frame(16'hF800, 20'h02000, 20'h12340, 20'hABCDE, 20'h13579,
               1, 256, 1, 0);
    chk("locked_after_rise", locked, 1);
    send_frame(16'h9000, 20'h7F000, 20'hFFFF0, 20'h24680, 20'h55555,
               1, 256, 1, 0);
    // early sync at bit 100
    send_frame(16'hF800, 20'h05000, 20'hBEEF0, 20'h11111, 20'h22222,
               1, 256, 1, 0);
    send_frame(16'hF800, 20'h06000, 20'h00000, 20'h99999, 20'h88888,
               1, 100, 0, 0);
    send_frame(16'hF800, 20'h07000, 20'hCAFE0, 20'h33333, 20'h44444,
               1, 256, 1, 1);
    // missing sync
    send_frame(16'hF800, 20'h08000, 20'h12120, 20'h55550, 20'h66660,
               1, 256, 0, 0);
    send_frame(16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000,
               0, 256, 0, 1);
    chk("locked_after_missing", locked, 0);
    send_frame(16'hF800, 20'h0A000, 20'hA5A50, 20'h77777, 20'h00001,
               1, 256, 1, 0);
    chk("relocked", locked, 1);
    // reset at bit 60
    send_frame(16'hE800, 20'h0B000, 20'h5A5A0, 20'h00002, 20'hFFFFF,
               1, 256, 1, 0);
    send_frame(16'hF800, 20'h0C000, 20'h13130, 20'h00003, 20'h00004,
               1, 60, 0, 0);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    clear_model();
    send_frame(16'hF800, 20'h0D000, 20'h14140, 20'h00005, 20'h00006,
               0, 196, 0, 0);
    chk("partial_unlocked", locked, 0);
    send_frame(16'hF800, 20'h0E000, 20'h15150, 20'h00007, 20'h00008,
               1, 256, 1, 0);
    // back-to-back frames with incrementing pcm_left
    for (int i = 0; i < 200; i++)
      send_frame(16'hF800, 20'h02000, 20'h12340, 20'(i), 20'h13579,
                 1, 256, 1, 0);
    send_frame(16'hF800, 20'h02000, 20'h12340, 20'hFFFFF, 20'h13579,
               1, 256, 0, 0);
    send_frame(16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000,
               0, 256, 0, 1);
    repeat (5) @(negedge clk);
    chk("pending_commits", cq.size(), 0);
    chk("pending_errs", eq.size(), 0);
    chk("final_locked", locked, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
